// File: rtl/game_status_ctrl.sv
// Snake game top-level sequencer: START/PLAY/END screen selection on frame
// boundaries, END-screen blink timing and the play re-initialise strobe.
module game_status_ctrl #(
    parameter int unsigned FRAMES_PER_TOGGLE = 30,
    parameter int unsigned FLASH_TOGGLES     = 8
) (
    input  logic       CLK_40M,
    input  logic       RST,
    input  logic       key_start,
    input  logic       die_sig,
    input  logic       vsync_in,
    output logic [2:0] Game_status,
    output logic       play_init,
    output logic       flash_on,
    output logic       Flash_over_sig
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAMES_PER_TOGGLE - 1);
    localparam logic [CNT_W-1:0] TOG_LAST   = CNT_W'(FLASH_TOGGLES);

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } state_t;

    state_t state;
    state_t state_n;

    logic             key_s1;
    logic             key_s2;
    logic             key_s3;
    logic             key_evt;
    logic             vsync_q;
    logic             vsync_qq;
    logic             frame_tick;

    logic             key_pend;
    logic             key_pend_n;
    logic             die_pend;
    logic             die_pend_n;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] frame_cnt_n;
    logic [CNT_W-1:0] tog_cnt;
    logic [CNT_W-1:0] tog_cnt_n;
    logic             flash_on_n;
    logic             flash_over_n;
    logic             play_init_n;

    // Key synchroniser with registered rising-edge detect; vsync edge register.
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            key_s1   <= 1'b0;
            key_s2   <= 1'b0;
            key_s3   <= 1'b0;
            key_evt  <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            key_s1   <= key_start;
            key_s2   <= key_s1;
            key_s3   <= key_s2;
            key_evt  <= key_s2 & ~key_s3;
            vsync_q  <= vsync_in;
            vsync_qq <= vsync_q;
        end
    end

    // Falling edge of the active-low VSYNC marks the start of a frame.
    assign frame_tick = vsync_qq & ~vsync_q;

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            state          <= ST_START;
            key_pend       <= 1'b0;
            die_pend       <= 1'b0;
            frame_cnt      <= '0;
            tog_cnt        <= '0;
            flash_on       <= 1'b0;
            Flash_over_sig <= 1'b0;
            play_init      <= 1'b0;
        end else begin
            state          <= state_n;
            key_pend       <= key_pend_n;
            die_pend       <= die_pend_n;
            frame_cnt      <= frame_cnt_n;
            tog_cnt        <= tog_cnt_n;
            flash_on       <= flash_on_n;
            Flash_over_sig <= flash_over_n;
            play_init      <= play_init_n;
        end
    end

    always_comb begin
        state_n      = state;
        key_pend_n   = key_pend;
        die_pend_n   = die_pend;
        frame_cnt_n  = frame_cnt;
        tog_cnt_n    = tog_cnt;
        flash_on_n   = flash_on;
        flash_over_n = Flash_over_sig;
        play_init_n  = 1'b0;

        case (state)
            ST_START: begin
                die_pend_n = 1'b0;
                if (frame_tick && (key_pend || key_evt)) begin
                    state_n     = ST_PLAY;
                    key_pend_n  = 1'b0;
                    play_init_n = 1'b1;
                end else begin
                    key_pend_n = key_pend | key_evt;
                end
            end

            ST_PLAY: begin
                // Keys are meaningless mid-game; collision wins any tie.
                key_pend_n = 1'b0;
                if (frame_tick && (die_pend || die_sig)) begin
                    state_n      = ST_END;
                    die_pend_n   = 1'b0;
                    frame_cnt_n  = '0;
                    tog_cnt_n    = '0;
                    flash_on_n   = 1'b0;
                    flash_over_n = 1'b0;
                end else begin
                    die_pend_n = die_pend | die_sig;
                end
            end

            ST_END: begin
                die_pend_n = 1'b0;
                if (Flash_over_sig) begin
                    if (frame_tick && (key_pend || key_evt)) begin
                        state_n      = ST_START;
                        key_pend_n   = 1'b0;
                        frame_cnt_n  = '0;
                        tog_cnt_n    = '0;
                        flash_on_n   = 1'b0;
                        flash_over_n = 1'b0;
                    end else begin
                        key_pend_n = key_pend | key_evt;
                    end
                end else begin
                    key_pend_n = 1'b0;
                    if (tog_cnt >= TOG_LAST) begin
                        flash_over_n = 1'b1;
                    end else if (frame_tick) begin
                        if (frame_cnt >= FRAME_LAST) begin
                            frame_cnt_n = '0;
                            flash_on_n  = ~flash_on;
                            tog_cnt_n   = tog_cnt + CNT_W'(1);
                        end else begin
                            frame_cnt_n = frame_cnt + CNT_W'(1);
                        end
                    end
                end
            end

            default: begin
                // Corrupted encoding: fall back to the title screen quietly.
                state_n      = ST_START;
                key_pend_n   = 1'b0;
                die_pend_n   = 1'b0;
                frame_cnt_n  = '0;
                tog_cnt_n    = '0;
                flash_on_n   = 1'b0;
                flash_over_n = 1'b0;
            end
        endcase
    end

    assign Game_status = state;

endmodule

// File: doc/game_status_ctrl.md
Name: game_status_ctrl

Overview:
- Top-level game sequencer for the snake game. Owns Game_status (one-hot START/PLAY/END) that drives the VGA output selector and the per-screen logic.
- Moves between screens only on a frame boundary, so the selected VGA source never switches mid-frame.
- Runs the END-screen blink timing, raises Flash_over_sig when the blink finishes, and pulses a re-initialise strobe into the play logic.

Parameters:
- FRAMES_PER_TOGGLE, 30, number of frame ticks between flash_on toggles in END; legal range 1..255.
- FLASH_TOGGLES, 8, number of flash_on toggles before Flash_over_sig asserts; legal range 1..255.

Ports:
- CLK_40M  input  1  system clock, 40 MHz.
- RST  input  1  synchronous reset, active-high.
- key_start  input  1  raw start push-button level, asynchronous, active-high.
- die_sig  input  1  one-cycle pulse from play logic: snake collision.
- vsync_in  input  1  active-low VSYNC from the currently selected VGA source.
- Game_status  output  3  one-hot state: 001 START, 010 PLAY, 100 END.
- play_init  output  1  one-cycle pulse that re-initialises snake/score logic.
- flash_on  output  1  END-screen blink phase.
- Flash_over_sig  output  1  level: END blink sequence complete.

Behaviour:
- Reset values: Game_status=001, play_init=0, flash_on=0, Flash_over_sig=0. All counters, pending flags and synchroniser flops clear to 0.
- Key path:
  - key_start goes through a 2-flop synchroniser, then rising-edge detect, giving key_evt (1 cycle).
  - key_evt first appears 3 cycles after key_start rises.
  - A held key produces exactly one key_evt.
- Frame tick:
  - vsync_in is registered once. frame_tick = previous registered value 1 and current registered value 0.
  - frame_tick is a 1-cycle pulse, once per frame.
- Pending flags:
  - key_pend sets on key_evt. die_pend sets on die_sig.
  - Both pending flags clear on every state transition.
  - A flag that sets in the same cycle as a transition is discarded.
- START:
  - If key_pend (or key_evt this cycle) is set at frame_tick, go to PLAY.
  - play_init is registered: it is high for exactly the first cycle in which Game_status=010.
- PLAY:
  - key_evt is ignored and key_pend is held at 0.
  - If die_pend (or die_sig this cycle) is set at frame_tick, go to END.
  - On entry to END: frame_cnt=0, tog_cnt=0, flash_on=0, Flash_over_sig=0.
- END blink timing:
  - Each frame_tick increments frame_cnt, while Flash_over_sig=0.
  - When frame_cnt reaches FRAMES_PER_TOGGLE-1 at a tick: frame_cnt returns to 0, flash_on toggles, tog_cnt increments.
  - When tog_cnt reaches FLASH_TOGGLES, Flash_over_sig goes to 1 on the next cycle. Counting then stops, flash_on freezes, and Flash_over_sig stays 1 while in END.
- END exit:
  - key_evt while Flash_over_sig=0 is ignored (key_pend held at 0).
  - Once Flash_over_sig=1, key_pend + frame_tick goes to START.
  - On that transition Flash_over_sig=0 and flash_on=0.
- Simultaneous events:
  - die_sig and key_evt in the same cycle in PLAY: die is taken, key is dropped.
  - Event arriving in the same cycle as frame_tick: the transition happens on that tick.
- Encoding:
  - Game_status is always one-hot.
  - Any non-one-hot value (SEU, X) returns to 001 on the next cycle, with no play_init.
- Reset mid-operation: RST in any state returns all outputs to their reset values on the next edge. Any in-progress blink or pending event is lost.
- Latency: key edge to Game_status change = 3 cycles + wait for the next frame_tick (bounded by one frame period, 16.7 ms at 60 Hz).
- die_sig must not be asserted by the play logic outside PLAY. Such pulses are ignored.

Test Plan:
Benches use FRAMES_PER_TOGGLE=2, FLASH_TOGGLES=4 and a frame period of 100 cycles.
- Reset then idle: after RST for 2 cycles, Game_status=001, all other outputs 0. No change over 5 frames with key_start=0.
- Start: pulse key_start for 20 cycles at cycle 10 → Game_status=010 on the cycle after the first frame_tick following cycle 13. play_init is high for that one cycle only. Holding the key 500 cycles gives no second event.
- Die + blink: in PLAY, pulse die_sig → END at the next frame_tick. flash_on toggles every 2 ticks (1,0,1,0). Flash_over_sig=1 one cycle after the 4th toggle (8 ticks after entry), and stays 1 with flash_on frozen at 0.
- Early key in END: press key before Flash_over_sig → state stays 100. Press after Flash_over_sig=1 → 001 at the next tick, Flash_over_sig=0, flash_on=0.
- Simultaneous: in PLAY, die_sig and key_evt in the same cycle → END. Key presses in PLAY alone → state stays 010.
- Reset mid-END: assert RST for 1 cycle during blink (tog_cnt=2) → next cycle Game_status=001, flash_on=0, Flash_over_sig=0, play_init=0.
